// File: rtl/core_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_ctrl
// Purpose  : Bridges single-word load/store strobes from the core controller
//            to a request/grant memory port with a separate read-data valid.
//            Rejects misaligned or conflicting strobes without touching memory,
//            and bounds both the grant wait and the read-data wait.
// Ports    : clk_i, rst_i              clock, synchronous active-high reset
//            re_mem_i, we_mem_i        read / write strobes (IDLE only)
//            addr_i, wdata_i           byte address, store data
//            busy_o, done_o, err_o     status; done_o is a one-cycle pulse
//            rdata_o                   last successfully read word
//            mem_req_o, mem_we_o,      memory request side, all zero while
//            mem_addr_o, mem_wdata_o   no request is outstanding
//            mem_gnt_i, mem_rvalid_i,  memory grant / read-data return
//            mem_rdata_i
// Revision : 1.0  initial release
// ============================================================================
module core_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              re_mem_i,
    input  logic              we_mem_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int         c_CNT_W   = 8;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [ADDR_W-1:0]   r_addr_q,  w_addr_d;
    logic [DATA_W-1:0]   r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0]   r_rdata_q, w_rdata_d;
    logic                r_we_q,    w_we_d;
    logic                r_err_q,   w_err_d;
    logic [c_CNT_W-1:0]  r_cnt_q,   w_cnt_d;

    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_timeout;
    logic                w_strobe_ok;
    logic                w_strobe_bad;
    logic                w_req;

    // The wait counter holds the number of cycles already spent in the
    // current wait state; the last allowed cycle is the one where the
    // incremented value would reach TIMEOUT. An event in that same cycle
    // still wins because it is tested first below.
    assign w_cnt_inc    = r_cnt_q + 8'd1;
    assign w_timeout    = (w_cnt_inc == c_TIMEOUT);
    assign w_strobe_ok  = (re_mem_i ^ we_mem_i) && (addr_i[1:0] == 2'b00);
    assign w_strobe_bad = (re_mem_i || we_mem_i) && !w_strobe_ok;

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;
        w_we_d    = r_we_q;
        w_err_d   = r_err_q;
        w_cnt_d   = r_cnt_q;

        unique case (r_state_q)
            S_IDLE: begin
                if (w_strobe_ok) begin
                    // Address is word-aligned here, so the latched copy is
                    // already the memory address.
                    w_addr_d  = addr_i;
                    w_wdata_d = wdata_i;
                    w_we_d    = we_mem_i;
                    w_err_d   = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = S_REQ;
                end else if (w_strobe_bad) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_RESP;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    w_cnt_d   = '0;
                    w_state_d = r_we_q ? S_RESP : S_WAIT_R;
                end else if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_RESP;
                end else begin
                    w_cnt_d   = w_cnt_inc;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid_i) begin
                    w_rdata_d = mem_rdata_i;
                    w_state_d = S_RESP;
                end else if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_RESP;
                end else begin
                    w_cnt_d   = w_cnt_inc;
                end
            end
            S_RESP: begin
                w_cnt_d   = '0;
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= S_IDLE;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
            r_we_q    <= 1'b0;
            r_err_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
            r_we_q    <= w_we_d;
            r_err_q   <= w_err_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // Memory-side outputs are gated so the bus reads as all-zero whenever
    // no request is outstanding.
    assign w_req       = (r_state_q == S_REQ);
    assign mem_req_o   = w_req;
    assign mem_we_o    = w_req & r_we_q;
    assign mem_addr_o  = w_req ? {r_addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata_o = w_req ? r_wdata_q : '0;

    assign busy_o  = (r_state_q != S_IDLE);
    assign done_o  = (r_state_q == S_RESP);
    assign err_o   = (r_state_q == S_RESP) & r_err_q;
    assign rdata_o = r_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_ctrl
// Purpose  : Self-checking bench for core_mem_ctrl. Each transaction is
//            described by its strobe cycle and the memory's grant/rvalid
//            delays; the expected cycle windows (busy, request, done) and
//            results are derived arithmetically and compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_core_mem_ctrl;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        re_mem_i, we_mem_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    core_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .re_mem_i     (re_mem_i),
        .we_mem_i     (we_mem_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int cyc      = 0;
    bit rst_prev = 1'b0;
    bit chk_en   = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst_i;
    end

    // Current transaction, expressed as cycle windows.
    int          t_s = 0, t_busy_lo = 0, t_busy_hi = -1;
    int          t_req_lo = 0, t_req_hi = -1, t_done = -1;
    bit          t_we = 1'b0, t_err = 1'b0, t_rd_ok = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0, t_rd_new = '0;
    logic [31:0] m_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        bit eb, er, ed;
        if (rst_prev) begin
            chk_en  = 1'b1;
            m_rdata = '0;
        end else if (cyc == t_done && t_rd_ok) begin
            m_rdata = t_rd_new;
        end
        if (chk_en) begin
            eb = (cyc >= t_busy_lo) && (cyc <= t_busy_hi);
            er = (cyc >= t_req_lo) && (cyc <= t_req_hi);
            ed = (cyc == t_done);
            chk("busy",      32'(busy_o),    32'(eb));
            chk("done",      32'(done_o),    32'(ed));
            chk("err",       32'(err_o),     32'(ed && t_err));
            chk("mem_req",   32'(mem_req_o), 32'(er));
            chk("mem_we",    32'(mem_we_o),  32'(er && t_we));
            chk("mem_addr",  mem_addr_o,     er ? t_addr  : 32'h0);
            chk("mem_wdata", mem_wdata_o,    er ? t_wdata : 32'h0);
            chk("rdata",     rdata_o,        m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_quiet();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
    endtask

    // Idle cycles with random noise on every input the controller must ignore.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            re_mem_i     = 1'b0;
            we_mem_i     = 1'b0;
            addr_i       = $urandom;
            wdata_i      = $urandom;
            mem_gnt_i    = 1'($urandom);
            mem_rvalid_i = 1'($urandom);
            mem_rdata_i  = $urandom;
        end
    endtask

    // g: REQ-cycle index of the grant (>= TO means never).
    // r: WAIT_R-cycle index of rvalid (>= TO means never).
    task automatic run_txn(input bit re, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int g, input int r,
                           input logic [31:0] rd, input bit noise);
        int  s, done, reqlast, c;
        bit  bad, ev;
        step();
        s   = cyc;
        bad = (re && we) || (addr[1:0] != 2'b00);
        t_rd_ok = 1'b0;
        t_err   = 1'b0;
        t_req_lo = s + 1;
        if (bad) begin
            done = s + 1;  t_err = 1'b1;  t_req_hi = s;
        end else if (g >= TO) begin
            done = s + 1 + TO;  t_err = 1'b1;  t_req_hi = s + TO;
        end else begin
            t_req_hi = s + 1 + g;
            if (we)          done = s + 2 + g;
            else if (r >= TO) begin done = s + 2 + g + TO; t_err = 1'b1; end
            else begin done = s + 3 + g + r; t_rd_ok = 1'b1; end
        end
        reqlast   = bad ? s : s + 1 + ((g < TO) ? g : TO - 1);
        t_s       = s;
        t_busy_lo = s + 1;
        t_busy_hi = done;
        t_done    = done;
        t_we      = we;
        t_addr    = {addr[31:2], 2'b00};
        t_wdata   = wdata;
        t_rd_new  = rd;

        re_mem_i = re;  we_mem_i = we;  addr_i = addr;  wdata_i = wdata;
        mem_gnt_i    = noise ? 1'($urandom) : 1'b0;
        mem_rvalid_i = noise ? 1'($urandom) : 1'b0;
        mem_rdata_i  = $urandom;

        for (int k = 1; k <= done - s; k++) begin
            step();
            c = s + k;
            re_mem_i = noise ? 1'($urandom) : 1'b0;
            we_mem_i = noise ? 1'($urandom) : 1'b0;
            addr_i   = $urandom;
            wdata_i  = $urandom;
            if (!bad && g < TO && c == s + 1 + g)  mem_gnt_i = 1'b1;
            else if (noise && c == done)            mem_gnt_i = 1'($urandom);
            else                                    mem_gnt_i = 1'b0;
            ev = !bad && !we && g < TO && r < TO && c == s + 2 + g + r;
            if (ev) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rd;
            end else begin
                mem_rvalid_i = noise && ((c >= s + 1 && c <= reqlast) || c == done)
                               ? 1'($urandom) : 1'b0;
                mem_rdata_i  = $urandom;
            end
        end
        #2;
    endtask

    task automatic reset_in_wait_r();
        int s;
        step();
        s = cyc;
        t_s = s;  t_busy_lo = s + 1;  t_busy_hi = s + 3;
        t_req_lo = s + 1;  t_req_hi = s + 1;  t_done = -1;
        t_we = 1'b0;  t_err = 1'b0;  t_rd_ok = 1'b0;
        t_addr = 32'h200;  t_wdata = 32'hA5A5A5A5;
        re_mem_i = 1'b1;  we_mem_i = 1'b0;  addr_i = 32'h200;  wdata_i = 32'hA5A5A5A5;
        mem_quiet();
        step();                                   // REQ, granted at once
        re_mem_i = 1'b0;  mem_gnt_i = 1'b1;
        step();                                   // WAIT_R, nothing returned
        mem_gnt_i = 1'b0;
        step();                                   // reset plus an ignored strobe
        rst_i = 1'b1;  re_mem_i = 1'b1;  addr_i = 32'h300;
        step();                                   // late rvalid after reset
        rst_i = 1'b0;  re_mem_i = 1'b0;
        mem_rvalid_i = 1'b1;  mem_rdata_i = 32'h55AA55AA;
        #2;
        chk("rst_busy",  32'(busy_o),    32'h0);
        chk("rst_done",  32'(done_o),    32'h0);
        chk("rst_req",   32'(mem_req_o), 32'h0);
        chk("rst_rdata", rdata_o,        32'h0);
        step();
        mem_quiet();
        #2;
        chk("rst_late_rdata", rdata_o,   32'h0);
        chk("rst_late_busy",  32'(busy_o), 32'h0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
        $fatal(1);
    end

    initial begin : driver
        int k, g, r, pick;
        bit re, we;
        logic [31:0] a;

        rst_i = 1'b1;  re_mem_i = 1'b0;  we_mem_i = 1'b0;
        addr_i = '0;  wdata_i = '0;  mem_quiet();
        step();
        step();
        re_mem_i = 1'b1;  addr_i = 32'h40;        // strobe during reset
        step();
        rst_i = 1'b0;  re_mem_i = 1'b0;
        #2;
        chk("reset_busy",  32'(busy_o),    32'h0);
        chk("reset_req",   32'(mem_req_o), 32'h0);
        chk("reset_rdata", rdata_o,        32'h0);
        idle(2);

        // Basic read, minimum latency.
        run_txn(1, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
        chk("rd_latency", 32'(t_done - t_s), 32'd3);
        chk("rd_done",    32'(done_o), 32'h1);
        chk("rd_err",     32'(err_o),  32'h0);
        chk("rd_data",    rdata_o,     32'hDEADBEEF);
        idle(1);

        // Write with a 3-cycle grant stall.
        run_txn(0, 1, 32'h24, 32'h12345678, 3, 0, 32'h0, 0);
        chk("wr_req_len", 32'(t_req_hi - t_req_lo + 1), 32'd4);
        chk("wr_latency", 32'(t_done - t_s), 32'd5);
        chk("wr_err",     32'(err_o),  32'h0);
        chk("wr_rdata",   rdata_o,     32'hDEADBEEF);

        // Misaligned read, then both strobes.
        run_txn(1, 0, 32'h102, 32'h0, 0, 0, 32'h0, 0);
        chk("mis_latency", 32'(t_done - t_s), 32'd1);
        chk("mis_err",     32'(err_o), 32'h1);
        run_txn(1, 1, 32'h100, 32'h0, 0, 0, 32'h0, 0);
        chk("both_err",    32'(err_o), 32'h1);

        // Read-data timeout, then rvalid on the last allowed cycle.
        run_txn(1, 0, 32'h80, 32'h0, 0, TO, 32'h11111111, 0);
        chk("rto_latency", 32'(t_done - t_s), 32'(2 + TO));
        chk("rto_err",     32'(err_o), 32'h1);
        chk("rto_rdata",   rdata_o,    32'hDEADBEEF);
        run_txn(1, 0, 32'h84, 32'h0, 0, TO - 1, 32'hCAFEF00D, 0);
        chk("rlast_latency", 32'(t_done - t_s), 32'(2 + TO));
        chk("rlast_err",     32'(err_o), 32'h0);
        chk("rlast_rdata",   rdata_o,    32'hCAFEF00D);

        // Grant timeout, and grant on the last allowed cycle.
        run_txn(0, 1, 32'h88, 32'h0BADF00D, TO, 0, 32'h0, 0);
        chk("gto_latency", 32'(t_done - t_s), 32'(1 + TO));
        chk("gto_err",     32'(err_o), 32'h1);
        run_txn(0, 1, 32'h8C, 32'h600DF00D, TO - 1, 0, 32'h0, 0);
        chk("glast_err",   32'(err_o), 32'h0);

        // Extra strobes and stray memory handshakes while busy.
        run_txn(1, 0, 32'h104, 32'h0, 1, 1, 32'h0F0F0F0F, 1);
        chk("busy_rdata",  rdata_o, 32'h0F0F0F0F);

        reset_in_wait_r();

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 7);
            a = $urandom;
            re = 1'b0;  we = 1'b0;
            if (k == 0) begin
                re = 1'b1;  we = 1'b1;
            end else if (k == 1) begin
                re = 1'($urandom);  we = !re;
                a[1:0] = 2'($urandom_range(1, 3));
            end else begin
                re = (k <= 4);  we = !re;  a[1:0] = 2'b00;
            end
            pick = $urandom_range(0, 9);
            g = (pick < 6) ? $urandom_range(0, 2) : (pick < 8) ? TO - 1 : (pick == 8) ? TO : $urandom_range(0, TO - 1);
            pick = $urandom_range(0, 9);
            r = (pick < 6) ? $urandom_range(0, 2) : (pick < 8) ? TO - 1 : (pick == 8) ? TO : $urandom_range(0, TO - 1);
            run_txn(re, we, a, $urandom, g, r, $urandom, 1'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_mem_ctrl.md
CORE_MEM_CTRL -- requirements
Module: core_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter TIMEOUT, default 16, max cycles waiting on mem_gnt_i or mem_rvalid_i; legal range 2..255.
REQ-004 clk_i  in  1  core clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 re_mem_i  in  1  read request strobe from core controller.
REQ-007 we_mem_i  in  1  write request strobe from core controller.
REQ-008 addr_i  in  ADDR_W  byte address from memory address register.
REQ-009 wdata_i  in  DATA_W  store data from register file.
REQ-010 busy_o  out  1  transaction in progress; new strobes ignored.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 err_o  out  1  valid with done_o: misaligned, conflicting strobes, or timeout.
REQ-013 rdata_o  out  DATA_W  last successfully read word.
REQ-014 mem_req_o  out  1  memory request, held until granted.
REQ-015 mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o.
REQ-016 mem_addr_o  out  ADDR_W  word-aligned address; valid while mem_req_o.
REQ-017 mem_wdata_o  out  DATA_W  write data; valid while mem_req_o.
REQ-018 mem_gnt_i  in  1  memory accepts request in the cycle mem_req_o && mem_gnt_i.
REQ-019 mem_rvalid_i  in  1  read data valid, earliest 1 cycle after grant.
REQ-020 mem_rdata_i  in  DATA_W  read data.

Function
REQ-021 FSM states: IDLE, REQ, WAIT_R, RESP; exactly one active.
REQ-022 IDLE: re_mem_i xor we_mem_i with addr_i[1:0]==0 latches addr_i, wdata_i, direction -> REQ next cycle.
REQ-023 IDLE: re_mem_i && we_mem_i, or addr_i[1:0]!=0 with either strobe -> RESP with err flag set; no memory request issued.
REQ-024 REQ: mem_req_o=1 with latched values, stable until grant; grant on write -> RESP; grant on read -> WAIT_R.
REQ-025 WAIT_R: mem_rvalid_i captures mem_rdata_i into rdata_o -> RESP; mem_rvalid_i outside WAIT_R ignored.
REQ-026 RESP: done_o=1 for exactly one cycle, err_o = err flag, -> IDLE; rdata_o unchanged on write or error.
REQ-027 busy_o=1 in REQ, WAIT_R, RESP; 0 in IDLE; strobes while busy_o=1 are dropped, not queued.
REQ-028 Timeout counter cleared on entry to REQ and on entry to WAIT_R, increments each cycle there; reaching TIMEOUT without the awaited event -> RESP with err; mem_req_o deasserts that cycle.
REQ-029 Grant or rvalid in the same cycle the counter reaches TIMEOUT counts as success, not timeout.
REQ-030 Minimum latency strobe -> done_o: write 2 cycles (grant in first REQ cycle), read 3 cycles (rvalid 1 cycle after grant); error on strobe: 1 cycle.
REQ-031 mem_addr_o = latched address with bits [1:0] forced 0.
REQ-032 mem_we_o, mem_addr_o, mem_wdata_o are 0 when mem_req_o=0.

Reset
REQ-033 rst_i=1 at a clock edge -> IDLE; busy_o, done_o, err_o, mem_req_o, mem_we_o = 0; mem_addr_o, mem_wdata_o, rdata_o, counter = 0.
REQ-034 Reset mid-transaction aborts it: no done_o, mem_req_o low next cycle; later mem_rvalid_i ignored.
REQ-035 Strobes in the reset cycle are ignored.

Verification
REQ-036 Read: re_mem_i, addr_i=0x100; gnt in 1st REQ cycle; rvalid next cycle with 0xDEADBEEF -> mem_addr_o=0x100, mem_we_o=0; done_o 3 cycles after strobe; rdata_o=0xDEADBEEF; err_o=0.
REQ-037 Write with stall: we_mem_i, addr_i=0x24, wdata_i=0x12345678; gnt after 3 cycles -> mem_req_o held 4 cycles, address/data stable; done_o next cycle; rdata_o unchanged.
REQ-038 Errors: addr_i=0x102 with re_mem_i, then both strobes at 0x100 -> each gives done_o && err_o 1 cycle later; mem_req_o never asserted.
REQ-039 Timeout: read, gnt granted, rvalid never -> done_o && err_o after TIMEOUT cycles in WAIT_R; repeat with rvalid on the TIMEOUT cycle -> err_o=0, data captured.
REQ-040 Busy/reset: second re_mem_i during busy_o ignored (one mem_req_o handshake); rst_i in WAIT_R -> all outputs 0 next cycle, no done_o, late rvalid ignored.
